// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared opcodes, instruction field positions, flag indices and FSM states
// Ports: none (package). Contents:
//   OP_*          5-bit opcodes
//   *_LSB / *_BIT instruction field positions
//   FLAG_*        bit indices inside the 4-bit flags word {sign, zero, overflow, carry}
//   state_t       execute FSM states
//   op_uses_rs1 / op_uses_rs2  which source register fields an opcode reads
package vpu_pkg;

   localparam logic [4:0] OP_MOVSGPR = 5'b00000;
   localparam logic [4:0] OP_MOV     = 5'b00001;
   localparam logic [4:0] OP_ADD     = 5'b00010;
   localparam logic [4:0] OP_SUB     = 5'b00011;
   localparam logic [4:0] OP_MUL     = 5'b00100;
   localparam logic [4:0] OP_OR      = 5'b00101;
   localparam logic [4:0] OP_AND     = 5'b00110;
   localparam logic [4:0] OP_XOR     = 5'b00111;
   localparam logic [4:0] OP_XNOR    = 5'b01000;
   localparam logic [4:0] OP_NAND    = 5'b01001;
   localparam logic [4:0] OP_NOR     = 5'b01010;
   localparam logic [4:0] OP_NOT     = 5'b01011;

   localparam int OP_LSB       = 27;
   localparam int RDST_LSB     = 22;
   localparam int RS1_LSB      = 17;
   localparam int IMM_MODE_BIT = 16;
   localparam int RS2_LSB      = 11;
   localparam int IMM_LSB      = 0;

   localparam int FLAG_SIGN  = 3;
   localparam int FLAG_ZERO  = 2;
   localparam int FLAG_OVF   = 1;
   localparam int FLAG_CARRY = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MUL,
      ST_RETIRE
   } state_t;

   // mov and not only read rsrc1 in register mode; movsgpr reads no GPR.
   function automatic logic op_uses_rs1(input logic [4:0] op, input logic imm_mode);
      logic used;
      used = 1'b0;
      if (op == OP_MOV || op == OP_NOT)
         used = ~imm_mode;
      else if (op >= OP_ADD && op <= OP_NOR)
         used = 1'b1;
      return used;
   endfunction

   // rsrc2 is only a real operand for the two-input ops in register mode.
   function automatic logic op_uses_rs2(input logic [4:0] op, input logic imm_mode);
      return (op >= OP_ADD) && (op <= OP_NOR) && !imm_mode;
   endfunction

endpackage

// File: rtl/vpu_seq_mul.sv
// rtl/vpu_seq_mul.sv - radix-2 shift-add unsigned multiplier, DATA_W iterations
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start     load a/b and begin; ignored-safe while idle only
//   a, b      DATA_W-bit unsigned operands
//   busy      high while iterations are in progress
//   done      one-cycle pulse after the last iteration; product valid from then on
//   product   2*DATA_W-bit result
module vpu_seq_mul #(
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  busy,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);

   localparam int CW = $clog2(DATA_W);

   logic [DATA_W-1:0]   mcand_q;
   logic [2*DATA_W-1:0] prod_q;
   logic [CW-1:0]       cnt_q;
   logic                busy_q;
   logic                done_q;
   logic [DATA_W:0]     addend;
   logic [DATA_W:0]     partial;

   // prod_q holds {running upper sum, remaining multiplier bits}; each step adds
   // the multiplicand when the current multiplier LSB is set, then shifts right.
   always_comb begin
      addend  = prod_q[0] ? {1'b0, mcand_q} : '0;
      partial = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + addend;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            mcand_q <= a;
            prod_q  <= {{DATA_W{1'b0}}, b};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
         end else if (busy_q) begin
            prod_q <= {partial, prod_q[DATA_W-1:1]};
            if (cnt_q == CW'(DATA_W - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = prod_q;

endmodule

// File: rtl/vpu_exec_core.sv
// rtl/vpu_exec_core.sv - clocked VPU execute stage with GPR file, SGPR, flags and sequential multiply
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   instr_valid  instruction present;  instr_ready  core can accept
//   instr        [31:27] op, [26:22] rdst, [21:17] rsrc1, [16] imm_mode, [15:11] rsrc2, [15:0] imm
//   dbg_addr     GPR read address;  dbg_data  GPR[dbg_addr], combinational
//   sgpr         high half of the last product
//   flags        {sign, zero, overflow, carry}
//   done         one-cycle pulse, legal instruction retired
//   illegal      one-cycle pulse, instruction rejected
module vpu_exec_core
   import vpu_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        instr_valid,
   output logic                        instr_ready,
   input  logic [31:0]                 instr,
   input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
   output logic [DATA_W-1:0]           dbg_data,
   output logic [DATA_W-1:0]           sgpr,
   output logic [3:0]                  flags,
   output logic                        done,
   output logic                        illegal
);

   localparam int RW = $clog2(NUM_REGS);

   state_t              state;
   logic                ready_q;
   logic                done_q;
   logic                illegal_q;
   logic [4:0]          op_q;
   logic [RW-1:0]       rd_q;
   logic                imm_q;
   logic                ill_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [DATA_W-1:0]   sgpr_q;
   logic [3:0]          flags_q;
   logic [DATA_W-1:0]   gpr [NUM_REGS];

   logic [4:0]          f_op;
   logic [4:0]          f_rd;
   logic [4:0]          f_rs1;
   logic [4:0]          f_rs2;
   logic                f_imm_mode;
   logic [15:0]         f_imm;
   logic [DATA_W-1:0]   rd_a;
   logic [DATA_W-1:0]   rd_b;
   logic                dec_illegal;
   logic                accept;
   logic                mul_start;

   logic                mul_busy;
   logic                mul_done;
   logic [2*DATA_W-1:0] mul_product;

   logic [DATA_W-1:0]   res;
   logic                res_c;
   logic                res_v;
   logic [DATA_W:0]     sum_ext;
   logic [DATA_W:0]     dif_ext;
   logic [3:0]          exec_flags;
   logic [3:0]          mul_flags;

   function automatic logic idx_bad(input logic [4:0] idx);
      return 6'(idx) >= 6'(NUM_REGS);
   endfunction

   // ---------------- decode of the incoming word ----------------
   assign f_op       = instr[OP_LSB +: 5];
   assign f_rd       = instr[RDST_LSB +: 5];
   assign f_rs1      = instr[RS1_LSB +: 5];
   assign f_rs2      = instr[RS2_LSB +: 5];
   assign f_imm_mode = instr[IMM_MODE_BIT];
   assign f_imm      = instr[IMM_LSB +: 16];

   // Operands are captured at accept, so an instruction whose rdst equals a
   // source always sees the pre-writeback value.
   assign rd_a = gpr[f_rs1[RW-1:0]];
   assign rd_b = f_imm_mode ? DATA_W'(f_imm) : gpr[f_rs2[RW-1:0]];

   always_comb begin
      dec_illegal = 1'b0;
      if (f_op > OP_NOT)
         dec_illegal = 1'b1;
      if (idx_bad(f_rd))
         dec_illegal = 1'b1;
      if (op_uses_rs1(f_op, f_imm_mode) && idx_bad(f_rs1))
         dec_illegal = 1'b1;
      if (op_uses_rs2(f_op, f_imm_mode) && idx_bad(f_rs2))
         dec_illegal = 1'b1;
   end

   // ready is forced low during reset so nothing can be accepted on a reset edge;
   // the multiplier interlock keeps a stray accept from restarting a live multiply.
   assign instr_ready = ready_q & ~rst & ~mul_busy;
   assign accept      = instr_valid & instr_ready;
   assign mul_start   = accept & (f_op == OP_MUL) & ~dec_illegal;

   vpu_seq_mul #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (rd_a),
      .b       (rd_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // ---------------- single-cycle ALU on the latched operands ----------------
   always_comb begin
      res     = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      sum_ext = {1'b0, a_q} + {1'b0, b_q};
      dif_ext = {1'b0, a_q} - {1'b0, b_q};
      case (op_q)
         OP_MOVSGPR: res = sgpr_q;
         OP_MOV:     res = imm_q ? b_q : a_q;
         OP_ADD: begin
            res   = sum_ext[DATA_W-1:0];
            res_c = sum_ext[DATA_W];
            res_v = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (res[DATA_W-1] != a_q[DATA_W-1]);
         end
         OP_SUB: begin
            res   = dif_ext[DATA_W-1:0];
            res_c = dif_ext[DATA_W];   // borrow out of the extended subtract
            res_v = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (res[DATA_W-1] != a_q[DATA_W-1]);
         end
         OP_OR:      res = a_q | b_q;
         OP_AND:     res = a_q & b_q;
         OP_XOR:     res = a_q ^ b_q;
         OP_XNOR:    res = ~(a_q ^ b_q);
         OP_NAND:    res = ~(a_q & b_q);
         OP_NOR:     res = ~(a_q | b_q);
         OP_NOT:     res = ~(imm_q ? b_q : a_q);
         default:    res = '0;
      endcase
   end

   always_comb begin
      exec_flags             = '0;
      exec_flags[FLAG_SIGN]  = res[DATA_W-1];
      exec_flags[FLAG_ZERO]  = (res == '0);
      exec_flags[FLAG_OVF]   = res_v;
      exec_flags[FLAG_CARRY] = res_c;
      mul_flags              = '0;
      mul_flags[FLAG_SIGN]   = mul_product[2*DATA_W-1];
      mul_flags[FLAG_ZERO]   = (mul_product == '0);
   end

   // ---------------- control FSM, register file and architectural state ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         op_q      <= '0;
         rd_q      <= '0;
         imm_q     <= 1'b0;
         ill_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sgpr_q    <= '0;
         flags_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            gpr[i] <= '0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state)
            ST_IDLE, ST_RETIRE: begin
               if (accept) begin
                  op_q    <= f_op;
                  rd_q    <= f_rd[RW-1:0];
                  imm_q   <= f_imm_mode;
                  ill_q   <= dec_illegal;
                  a_q     <= rd_a;
                  b_q     <= rd_b;
                  ready_q <= 1'b0;
                  // illegal multiplies take the short EXEC path and only report
                  state   <= mul_start ? ST_MUL : ST_EXEC;
               end else begin
                  ready_q <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               if (!ill_q) begin
                  gpr[rd_q] <= res;
                  flags_q   <= exec_flags;
               end
               done_q    <= ~ill_q;
               illegal_q <= ill_q;
               ready_q   <= 1'b1;
               state     <= ST_RETIRE;
            end
            ST_MUL: begin
               if (mul_done) begin
                  gpr[rd_q] <= mul_product[DATA_W-1:0];
                  sgpr_q    <= mul_product[2*DATA_W-1:DATA_W];
                  flags_q   <= mul_flags;
                  done_q    <= 1'b1;
                  ready_q   <= 1'b1;
                  state     <= ST_RETIRE;
               end
            end
            default: begin
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign dbg_data = gpr[dbg_addr];
   assign sgpr     = sgpr_q;
   assign flags    = flags_q;
   assign done     = done_q;
   assign illegal  = illegal_q;

endmodule
